// File: rtl/alu_operand_fetch_pkg.sv
// Shared types for the ALU operand-fetch block: operand source encodings,
// fetch FSM states and the operand-index width helper.
package alu_operand_fetch_pkg;

  localparam int SRC_W = 3;

  // Encodings 4..7 are illegal and flag out_err.
  typedef enum logic [SRC_W-1:0] {
    SRC_MEM_ADDR  = 3'd0,
    SRC_IMMEDIATE = 3'd1,
    SRC_INDIRECT  = 3'd2,
    SRC_REG       = 3'd3
  } data_src_t;

  typedef enum logic [2:0] {
    IDLE,
    RESOLVE,
    ISSUE,
    WAIT,
    DONE
  } fetch_state_t;

  function automatic int op_idx_width(input int n_ops);
    return (n_ops > 1) ? $clog2(n_ops) : 1;
  endfunction

endpackage

// File: rtl/mem_rd_tracker.sv
// Single-outstanding data-memory read engine: issues a one-cycle strobe,
// counts the fixed read latency and pulses rsp_valid with the returned word.
module mem_rd_tracker #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  abort,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [CNT_W-1:0] cnt;

  // The counter loads behind the strobe and expires in the cycle the data is valid.
  always_ff @(posedge clk) begin
    if (abort) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      cnt         <= '0;
    end else begin
      mem_rd_en <= start;
      if (start) begin
        mem_rd_addr <= start_addr;
      end
      if (mem_rd_en) begin
        cnt <= CNT_W'(MEM_LATENCY);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign rsp_valid = !abort && (cnt == CNT_W'(1));
  assign rsp_data  = mem_rd_data;

endmodule

// File: rtl/alu_operand_fetch.sv
// Multi-cycle operand fetch between decode and ALU: resolves N_OPS operands in
// order from immediate, register, direct or indirect memory addressing.
module alu_operand_fetch
  import alu_operand_fetch_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int N_OPS       = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [N_OPS*SRC_W-1:0]   req_src,
  input  logic [N_OPS*WIDTH-1:0]   req_operand,
  input  logic [N_OPS*WIDTH-1:0]   rf_data,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [WIDTH-1:0]         mem_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OPS*WIDTH-1:0]   out_data,
  output logic                     out_err
);

  localparam int OP_IDX_W = op_idx_width(N_OPS);

  fetch_state_t          state, state_nxt;
  logic [OP_IDX_W-1:0]   idx;
  data_src_t             src_q  [N_OPS];
  logic [WIDTH-1:0]      opnd_q [N_OPS];
  logic [WIDTH-1:0]      rf_q   [N_OPS];
  logic [WIDTH-1:0]      res_q  [N_OPS];
  logic                  err_q;
  logic                  second_q;

  logic                  accept;
  logic                  cur_last;
  logic                  is_mem;
  logic                  need_ptr;
  logic                  op_done;
  logic                  rd_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  data_src_t             cur_src;
  logic [WIDTH-1:0]      cur_opnd;
  logic [WIDTH-1:0]      cur_rf;

  // A data word becomes an address by truncation or zero extension.
  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [WIDTH-1:0] w);
    return ADDR_WIDTH'(w);
  endfunction

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign out_valid = (state == DONE);
  assign out_err   = err_q;

  assign cur_src  = src_q[idx];
  assign cur_opnd = opnd_q[idx];
  assign cur_rf   = rf_q[idx];
  assign cur_last = (idx == OP_IDX_W'(N_OPS - 1));
  assign is_mem   = (cur_src == SRC_MEM_ADDR) || (cur_src == SRC_INDIRECT);
  assign need_ptr = (cur_src == SRC_INDIRECT) && !second_q;
  assign op_done  = ((state == RESOLVE) && !is_mem) ||
                    ((state == WAIT) && rsp_valid && !need_ptr);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    rd_start  = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (is_mem) begin
          state_nxt = ISSUE;
          rd_start  = 1'b1;
          rd_addr   = to_addr(cur_opnd);
        end else begin
          state_nxt = cur_last ? DONE : RESOLVE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (rsp_valid) begin
          if (need_ptr) begin
            state_nxt = ISSUE;
            rd_start  = 1'b1;
            rd_addr   = to_addr(rsp_data);
          end else begin
            state_nxt = cur_last ? DONE : RESOLVE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      err_q    <= 1'b0;
      second_q <= 1'b0;
      for (int i = 0; i < N_OPS; i++) res_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx      <= '0;
        err_q    <= 1'b0;
        second_q <= 1'b0;
        for (int i = 0; i < N_OPS; i++) res_q[i] <= '0;
      end else begin
        if (state == RESOLVE) begin
          case (cur_src)
            SRC_IMMEDIATE:              res_q[idx] <= cur_opnd;
            SRC_REG:                    res_q[idx] <= cur_rf;
            SRC_MEM_ADDR, SRC_INDIRECT: ;
            default: begin
              res_q[idx] <= '0;
              err_q      <= 1'b1;
            end
          endcase
        end
        // The first word of an indirect fetch is only a pointer.
        if ((state == WAIT) && rsp_valid) begin
          if (need_ptr) begin
            second_q <= 1'b1;
          end else begin
            res_q[idx] <= rsp_data;
            second_q   <= 1'b0;
          end
        end
        if (op_done && !cur_last) idx <= idx + 1'b1;
      end
    end
  end

  // NOTE: request payload registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_OPS; i++) begin
        src_q[i]  <= data_src_t'(req_src[i*SRC_W +: SRC_W]);
        opnd_q[i] <= req_operand[i*WIDTH +: WIDTH];
        rf_q[i]   <= rf_data[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < N_OPS; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = res_q[g];
  end

  mem_rd_tracker #(
    .WIDTH       (WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_rd (
    .clk         (clk),
    .abort       (!rst_n),
    .start       (rd_start),
    .start_addr  (rd_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: a behavioural operand model feeds
// expectation queues that independent monitors check against the DUT.
module tb_alu_operand_fetch;
  import alu_operand_fetch_pkg::*;

  localparam int W   = 8;
  localparam int AW  = 8;
  localparam int NO  = 2;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [NO*SRC_W-1:0] req_src = '0;
  logic [NO*W-1:0]   req_operand = '0;
  logic [NO*W-1:0]   rf_data = '0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [W-1:0]      mem_rd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NO*W-1:0]   out_data;
  logic              out_err;

  alu_operand_fetch #(
    .WIDTH(W), .ADDR_WIDTH(AW), .N_OPS(NO), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_operand(req_operand), .rf_data(rf_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mem [256];

  typedef struct packed {
    logic [NO*W-1:0] data;
    logic            err;
    logic [31:0]     due;
    logic [31:0]     hold;
  } exp_t;

  typedef struct packed {
    logic [31:0]   due;
    logic [AW-1:0] addr;
  } pend_t;

  exp_t          exp_q [$];
  logic [AW-1:0] addr_q [$];
  pend_t         pend_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value, error flag and cycle cost of one operand, queueing expected reads.
  task automatic model_op(input logic [SRC_W-1:0] s, input logic [W-1:0] op, input logic [W-1:0] rf,
                          output logic [W-1:0] v, output logic e, output int cost);
    logic [W-1:0] p;
    v = '0; e = 1'b0; cost = 1;
    case (s)
      SRC_IMMEDIATE: v = op;
      SRC_REG:       v = rf;
      SRC_MEM_ADDR: begin
        addr_q.push_back(op);
        v = mem[op];
        cost = 2 + LAT;
      end
      SRC_INDIRECT: begin
        addr_q.push_back(op);
        p = mem[op];
        addr_q.push_back(p);
        v = mem[p];
        cost = 3 + 2 * LAT;
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic send(input logic [SRC_W-1:0] s0, input logic [W-1:0] o0, input logic [W-1:0] r0,
                      input logic [SRC_W-1:0] s1, input logic [W-1:0] o1, input logic [W-1:0] r1,
                      input int hold);
    exp_t x;
    logic [W-1:0] v0, v1;
    logic e0, e1;
    int c0, c1, t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_wait", req_ready, 1);
    if (req_ready !== 1'b1) return;
    req_valid   = 1'b1;
    req_src     = {s1, s0};
    req_operand = {o1, o0};
    rf_data     = {r1, r0};
    model_op(s0, o0, r0, v0, e0, c0);
    model_op(s1, o1, r1, v1, e1, c1);
    x.data = {v1, v0};
    x.err  = e0 | e1;
    x.due  = 32'(cyc + 1 + c0 + c1);
    x.hold = 32'(hold);
    exp_q.push_back(x);
    @(negedge clk);
    req_valid   = 1'b0;
    req_src     = NO*SRC_W'($urandom);
    req_operand = NO*W'($urandom);
    rf_data     = NO*W'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_idle", {exp_q.size() == 0, req_ready}, 2'b11);
  endtask

  // Memory model: checks each strobe and returns data exactly LAT cycles later.
  initial begin : mem_model
    pend_t pe;
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
        check("single_outstanding", pend_q.size(), 0);
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: addr 0x%0h with no read expected (cycle %0d)", mem_rd_addr, cyc);
        end else begin
          check("strobe_addr", mem_rd_addr, addr_q.pop_front());
        end
        pe.due  = 32'(cyc + LAT);
        pe.addr = mem_rd_addr;
        pend_q.push_back(pe);
      end
      if (pend_q.size() != 0 && pend_q[0].due == 32'(cyc)) begin
        pe = pend_q.pop_front();
        mem_rd_data = mem[pe.addr];
      end else begin
        mem_rd_data = W'($urandom);
      end
    end
  end

  // Output monitor: pops one expectation per out_valid episode and owns out_ready.
  initial begin : monitor
    exp_t cur;
    logic have, hs_prev;
    int   wait_n;
    have = 1'b0; hs_prev = 1'b0; wait_n = 0;
    forever begin
      @(negedge clk);
      if (hs_prev) check("req_ready_after_done", req_ready, 1);
      hs_prev = 1'b0;
      if (out_valid === 1'b1) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: data 0x%0h with no request pending (cycle %0d)", out_data, cyc);
          end else begin
            cur    = exp_q.pop_front();
            have   = 1'b1;
            wait_n = int'(cur.hold);
            check("out_valid_latency", 64'(cyc), 64'(cur.due));
          end
        end
        if (have) begin
          check("out_data", out_data, cur.data);
          check("out_err", out_err, cur.err);
          check("req_ready_in_done", req_ready, 0);
          if (wait_n > 0) begin
            out_ready = 1'b0;
            wait_n--;
          end else begin
            out_ready = 1'b1;
            have      = 1'b0;
            hs_prev   = 1'b1;
          end
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [SRC_W-1:0] s [2];
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
    mem[8'h40] = 8'hA5;
    mem[8'h10] = 8'h80;
    mem[8'h80] = 8'h5C;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_req_ready_low", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Immediate + register, direct read, indirect read, long hold, illegal then clean.
    send(SRC_IMMEDIATE, 8'h12, 8'h00, SRC_REG, 8'h00, 8'h34, 0);
    send(SRC_MEM_ADDR, 8'h40, 8'h00, SRC_IMMEDIATE, 8'h77, 8'h00, 1);
    send(SRC_INDIRECT, 8'h10, 8'h00, SRC_REG, 8'h00, 8'h9E, 0);
    send(SRC_MEM_ADDR, 8'h40, 8'h00, SRC_INDIRECT, 8'h10, 8'h00, 5);
    send(SRC_IMMEDIATE, 8'h3C, 8'h00, 3'd5, 8'hFF, 8'hEE, 0);
    send(SRC_REG, 8'h00, 8'h61, SRC_IMMEDIATE, 8'h2B, 8'h00, 0);
    drain();

    // Reset while the first read of an indirect fetch is in flight.
    @(negedge clk);
    req_valid   = 1'b1;
    req_src     = {SRC_W'(SRC_IMMEDIATE), SRC_W'(SRC_INDIRECT)};
    req_operand = {8'h55, 8'h10};
    rf_data     = '0;
    addr_q.push_back(8'h10);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mem_rd_en", mem_rd_en, 0);
    check("midrst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", req_ready, 1);
    check("midrst_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_stale", {out_valid, out_data}, 0);
    send(SRC_MEM_ADDR, 8'h40, 8'h00, SRC_IMMEDIATE, 8'h01, 8'h00, 0);
    drain();

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 9) < 8) s[k] = SRC_W'($urandom_range(0, 3));
        else                          s[k] = SRC_W'($urandom_range(4, 7));
      end
      send(s[0], W'($urandom), W'($urandom), s[1], W'($urandom), W'($urandom),
           int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);
    check("reads_all_issued", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
